// File: rtl/apb_regfile_slave_pkg.sv
// apb_slv_pkg: shared state encoding, constants and address decode for apb_regfile_slave.
package apb_slv_pkg;
    typedef enum logic {IDLE, ACCESS} apb_slv_state_e;
    localparam int unsigned APB_SLV_ID_IDX = 0;
    localparam int unsigned APB_SLV_WAIT_W = 4;
    function automatic logic apb_slv_decode_err(input logic [31:0] addr, input logic write,
                                                input int unsigned num_regs);
        return addr[1:0] != 2'b00 || {2'b00, addr[31:2]} >= num_regs
            || (write && {2'b00, addr[31:2]} == APB_SLV_ID_IDX);
    endfunction
endpackage

// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB bus bundle with master and slave views.
interface apb_regfile_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;
    modport master (output paddr, psel, penable, pwrite, pwdata, input pready, prdata, pslverr);
    modport slave (input paddr, psel, penable, pwrite, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_regfile_slave_regbank.sv
// apb_slv_regbank: register array with one write port and a read mux; reg 0 holds the ID constant.
module apb_slv_regbank
    import apb_slv_pkg::*;
#(
    parameter int          NUM_REGS   = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'hA9B0_0001,
    parameter int          IW         = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IW-1:0]                  idx,
    input  logic [DATA_WIDTH-1:0]          data,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) mem[k] <= '0;
            mem[APB_SLV_ID_IDX] <= ID_VALUE;
        end else if (we) begin
            mem[idx] <= data;
        end
    end
    // guard covers non-power-of-two bank sizes
    assign rdata = int'(idx) < NUM_REGS ? mem[idx] : '0;
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end
endmodule

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB completer over a small register bank with decode errors.
// Wait states are inserted only when APB_SLV_WAIT_EN is defined; otherwise every access is zero-wait.
module apb_regfile_slave
    import apb_slv_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
    localparam int         IW          = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    apb_regfile_slave_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic                           wr_pulse,
    output logic [IW-1:0]                  wr_idx
);
    apb_slv_state_e        state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdy;
    logic                  err;
    logic                  we;
`ifdef APB_SLV_WAIT_EN
    logic [APB_SLV_WAIT_W-1:0] cnt;
    assign rdy = state == ACCESS && bus.psel && cnt == '0;
`else
    assign rdy = state == ACCESS && bus.psel;
`endif
    // decode works off the address latched in setup
    assign err = apb_slv_decode_err(32'(addr_q), bus.pwrite, NUM_REGS);
    assign we = rdy && bus.penable && bus.pwrite && !err;
    assign bus.pready = rdy;
    assign bus.pslverr = rdy && err;
    assign bus.prdata = rdy && !err ? rdata : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr_q <= '0;
            wr_pulse <= 1'b0;
            wr_idx <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt <= '0;
`endif
        end else begin
            wr_pulse <= we;
            if (we) wr_idx <= addr_q[IW+1:2];
            if (state == IDLE) begin
                if (bus.psel && !bus.penable) begin
                    state <= ACCESS;
                    addr_q <= bus.paddr;
`ifdef APB_SLV_WAIT_EN
                    cnt <= APB_SLV_WAIT_W'(WAIT_CYCLES);
`endif
                end
            end else if (!bus.psel || (rdy && bus.penable)) begin
                state <= IDLE;
            end
`ifdef APB_SLV_WAIT_EN
            else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
`endif
        end
    end
    apb_slv_regbank #(
        .NUM_REGS  (NUM_REGS),
        .DATA_WIDTH(DATA_WIDTH),
        .ID_VALUE  (ID_VALUE),
        .IW        (IW)
    ) u_regbank (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .idx  (addr_q[IW+1:2]),
        .data (bus.pwdata),
        .rdata(rdata),
        .regs (regs_o)
    );
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed checks of reads, writes, decode errors, wait states, aborts and reset.
module tb_apb_regfile_slave;
    localparam int          AW = 12;
    localparam int          DW = 32;
    localparam int          NR = 8;
    localparam int          WC = 3;
    localparam logic [31:0] ID = 32'hA9B0_0001;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAITS = WC;
`else
    localparam int EXP_WAITS = 0;
`endif
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR*DW-1:0] regs_o;
    logic             wr_pulse;
    logic [2:0]       wr_idx;
    int               tests = 0;
    int               fails = 0;

    apb_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_regfile_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .WAIT_CYCLES(WC),
        .ID_VALUE   (ID)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .regs_o  (regs_o),
        .wr_pulse(wr_pulse),
        .wr_idx  (wr_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rg(input int i);
        return regs_o[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.psel = 1'b0;
        bus.penable = 1'b0;
    endtask

    // starts at posedge+1, returns at posedge+1 just after the completing edge with the bus still driven
    task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int waits);
        bus.psel = 1'b1;
        bus.penable = 1'b0;
        bus.paddr = a;
        bus.pwrite = w;
        bus.pwdata = d;
        waits = 0;
        rd = '0;
        err = 1'b0;
        tick();
        bus.penable = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.pready) begin
                rd = bus.prdata;
                err = bus.pslverr;
                break;
            end
            waits++;
            if (waits > 20) begin
                tests++;
                fails++;
                $display("FAIL xfer_timeout addr=%h pready actual=0 required=1", a);
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        err;
        int          w;
        idle();
        bus.paddr = '0;
        bus.pwrite = 1'b0;
        bus.pwdata = '0;
        repeat (2) @(negedge clk);
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL reset_pready actual=%b required=0", bus.pready); end
        tests++; if (bus.prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata actual=%h required=0", bus.prdata); end
        tests++; if (bus.pslverr !== 1'b0) begin fails++; $display("FAIL reset_pslverr actual=%b required=0", bus.pslverr); end
        tests++; if (wr_pulse !== 1'b0) begin fails++; $display("FAIL reset_wr_pulse actual=%b required=0", wr_pulse); end
        tests++; if (wr_idx !== 3'd0) begin fails++; $display("FAIL reset_wr_idx actual=%0d required=0", wr_idx); end
        tests++; if (rg(0) !== ID) begin fails++; $display("FAIL reset_reg0 actual=%h required=%h", rg(0), ID); end
        tests++; if (regs_o[NR*DW-1:32] !== '0) begin fails++; $display("FAIL reset_regs actual=%h required=0", regs_o[NR*DW-1:32]); end
        tick();
        rst = 1'b0;
        tick();
        xfer(12'h000, 1'b0, 32'h0, rd, err, w);
        idle();
        tests++; if (rd !== ID) begin fails++; $display("FAIL read_id prdata actual=%h required=%h", rd, ID); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL read_id pslverr actual=%b required=0", err); end
        tick();
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        err;
        int          w;
        xfer(12'h004, 1'b1, 32'hDEAD_BEEF, rd, err, w);
        idle();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL wr4_pslverr actual=%b required=0", err); end
        @(negedge clk);
        tests++; if (wr_pulse !== 1'b1) begin fails++; $display("FAIL wr4_pulse actual=%b required=1", wr_pulse); end
        tests++; if (wr_idx !== 3'd1) begin fails++; $display("FAIL wr4_idx actual=%0d required=1", wr_idx); end
        tests++; if (rg(1) !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr4_regs actual=%h required=deadbeef", rg(1)); end
        tick();
        @(negedge clk);
        tests++; if (wr_pulse !== 1'b0) begin fails++; $display("FAIL wr4_pulse_width actual=%b required=0", wr_pulse); end
        tests++; if (wr_idx !== 3'd1) begin fails++; $display("FAIL wr4_idx_hold actual=%0d required=1", wr_idx); end
        tick();
        xfer(12'h004, 1'b0, 32'h0, rd, err, w);
        idle();
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd4_prdata actual=%h required=deadbeef", rd); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rd4_pslverr actual=%b required=0", err); end
        tick();
    endtask

    task automatic test_errors();
        logic [11:0]      addrs [3] = '{12'h000, 12'h020, 12'h006};
        logic             wrs   [3] = '{1'b1, 1'b1, 1'b0};
        logic [NR*DW-1:0] snap;
        logic [31:0]      rd;
        logic             err;
        int               w;
        for (int i = 0; i < 3; i++) begin
            snap = regs_o;
            xfer(addrs[i], wrs[i], 32'h1234_5678, rd, err, w);
            idle();
            tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_%h pslverr actual=%b required=1", addrs[i], err); end
            tests++; if (rd !== 32'h0) begin fails++; $display("FAIL err_%h prdata actual=%h required=0", addrs[i], rd); end
            @(negedge clk);
            tests++; if (wr_pulse !== 1'b0) begin fails++; $display("FAIL err_%h wr_pulse actual=%b required=0", addrs[i], wr_pulse); end
            tests++; if (regs_o !== snap) begin fails++; $display("FAIL err_%h regs actual=%h required=%h", addrs[i], regs_o, snap); end
            tests++; if (bus.pslverr !== 1'b0) begin fails++; $display("FAIL err_%h pslverr_idle actual=%b required=0", addrs[i], bus.pslverr); end
            tick();
        end
    endtask

    task automatic test_wait();
        logic [31:0] rd;
        logic        err;
        int          w;
        xfer(12'h004, 1'b0, 32'h0, rd, err, w);
        idle();
        tests++; if (w != EXP_WAITS) begin fails++; $display("FAIL wait_states actual=%0d required=%0d", w, EXP_WAITS); end
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wait_prdata actual=%h required=deadbeef", rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd0, rd1;
        logic        e0, e1;
        int          w0, w1;
        xfer(12'h008, 1'b1, 32'hCAFE_F00D, rd0, e0, w0);
        xfer(12'h008, 1'b0, 32'h0, rd1, e1, w1);
        idle();
        tests++; if (e0 !== 1'b0 || e1 !== 1'b0) begin fails++; $display("FAIL b2b_pslverr actual=%b%b required=00", e0, e1); end
        tests++; if (rd1 !== 32'hCAFE_F00D) begin fails++; $display("FAIL b2b_prdata actual=%h required=cafef00d", rd1); end
        tests++; if (w1 != EXP_WAITS) begin fails++; $display("FAIL b2b_waits actual=%0d required=%0d", w1, EXP_WAITS); end
        tests++; if (rg(2) !== 32'hCAFE_F00D) begin fails++; $display("FAIL b2b_reg2 actual=%h required=cafef00d", rg(2)); end
        tick();
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        err;
        int          w;
        xfer(12'h00C, 1'b1, 32'h1111_2222, rd, err, w);
        idle();
        tick();
        bus.psel = 1'b1;
        bus.paddr = 12'h00C;
        bus.pwrite = 1'b1;
        bus.pwdata = 32'h3333_4444;
        tick();
        bus.psel = 1'b0;
        bus.penable = 1'b1;
        @(negedge clk);
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL abort_pready actual=%b required=0", bus.pready); end
        tick();
        bus.psel = 1'b1;
        @(negedge clk);
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL abort_idle pready actual=%b required=0", bus.pready); end
        tick();
        idle();
        @(negedge clk);
        tests++; if (rg(3) !== 32'h1111_2222) begin fails++; $display("FAIL abort_reg3 actual=%h required=11112222", rg(3)); end
        tests++; if (wr_pulse !== 1'b0) begin fails++; $display("FAIL abort_wr_pulse actual=%b required=0", wr_pulse); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.psel = 1'b1;
        bus.penable = 1'b0;
        bus.paddr = 12'h00C;
        bus.pwrite = 1'b1;
        bus.pwdata = 32'h5555_6666;
        tick();
        bus.penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL rstmid_pready actual=%b required=0", bus.pready); end
        tests++; if (rg(3) !== 32'h0) begin fails++; $display("FAIL rstmid_reg3 actual=%h required=0", rg(3)); end
        tests++; if (rg(0) !== ID || rg(1) !== 32'h0) begin fails++; $display("FAIL rstmid_regs actual=%h_%h required=%h_0", rg(0), rg(1), ID); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL rstmid_idle pready actual=%b required=0", bus.pready); end
        tests++; if (rg(3) !== 32'h0) begin fails++; $display("FAIL rstmid_dropped reg3 actual=%h required=0", rg(3)); end
        tick();
        idle();
        @(negedge clk);
        tests++; if (wr_pulse !== 1'b0) begin fails++; $display("FAIL rstmid_wr_pulse actual=%b required=0", wr_pulse); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_wait();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
